// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline stall combiner, divider sequencer, stall/timeout counters
module stall_ctrl #(
    parameter int DIV_LAT     = 32,
    parameter int MEM_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        div_req,
    input  logic        stallreq_mem,
    output logic [5:0]  stall,
    output logic        div_start,
    output logic        div_busy,
    output logic        div_ready,
    output logic [31:0] stall_cycles,
    output logic        mem_timeout
);

    localparam int CW = $clog2(DIV_LAT + 1);
    localparam int MW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [MW-1:0] mem_cnt;
    logic          ex_req;

    // EX only asks for a freeze while the divide result is not yet available
    assign ex_req = div_req & (state != S_DONE);

    // Priority stall encoder: MEM over EX over ID; lower requests are simply masked
    always_comb begin
        stall = 6'b000000;
        if (stallreq_mem) begin
            stall = 6'b011111;
        end else if (ex_req) begin
            stall = 6'b001111;
        end else if (stallreq_id) begin
            stall = 6'b000111;
        end
    end

    // Start is withheld while MEM is stalling so operands are latched from a live EX
    assign div_start = (state == S_IDLE) & div_req & ~stallreq_mem;
    assign div_busy  = (state == S_BUSY);
    assign div_ready = (state == S_DONE);

    // Divider occupancy sequencer; BUSY keeps counting even under a MEM stall
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (div_start) begin
                        cnt   <= CW'(DIV_LAT - 1);
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt == '0) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    if (!stall[3]) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall[0] && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

    // Run length of consecutive MEM stall cycles, saturating at the timeout value
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_cnt <= '0;
        end else if (!stallreq_mem) begin
            mem_cnt <= '0;
        end else if (mem_cnt != MW'(MEM_TIMEOUT)) begin
            mem_cnt <= mem_cnt + MW'(1);
        end
    end

    // Sticky timeout: set in step with mem_cnt reaching the limit, not a cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_timeout <= 1'b0;
        end else if (stallreq_mem && (mem_cnt >= MW'(MEM_TIMEOUT - 1))) begin
            mem_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// tb/tb_stall_ctrl.sv - self-checking bench for stall_ctrl
module tb_stall_ctrl;

    localparam int DIV_LAT     = 4;
    localparam int MEM_TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        div_req;
    logic        stallreq_mem;
    logic [5:0]  stall;
    logic        div_start;
    logic        div_busy;
    logic        div_ready;
    logic [31:0] stall_cycles;
    logic        mem_timeout;

    stall_ctrl #(.DIV_LAT(DIV_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .div_req(div_req),
        .stallreq_mem(stallreq_mem), .stall(stall), .div_start(div_start),
        .div_busy(div_busy), .div_ready(div_ready), .stall_cycles(stall_cycles),
        .mem_timeout(mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the divide is described by the cycle it was started,
    // the counters by plain integers.
    int  cyc;
    bit  m_active;
    int  m_start;
    longint m_sc;
    int  m_run;
    bit  m_to;

    logic [5:0] e_stall;
    logic       e_start, e_busy, e_ready;

    typedef struct {
        logic       r, id, dq, mm;
        logic [5:0] stall;
        logic       start, busy, ready;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_outputs();
        bit ready;
        ready   = m_active && ((cyc - m_start) > DIV_LAT);
        e_ready = ready;
        e_busy  = m_active && !ready;
        if (stallreq_mem)                e_stall = 6'b011111;
        else if (div_req && !ready)      e_stall = 6'b001111;
        else if (stallreq_id)            e_stall = 6'b000111;
        else                             e_stall = 6'b000000;
        e_start = !m_active && div_req && !stallreq_mem;
    endtask

    task automatic check_model(input string tag);
        model_outputs();
        check({tag, ".stall"}, 32'(stall), 32'(e_stall));
        check({tag, ".div_start"}, 32'(div_start), 32'(e_start));
        check({tag, ".div_busy"}, 32'(div_busy), 32'(e_busy));
        check({tag, ".div_ready"}, 32'(div_ready), 32'(e_ready));
        check({tag, ".stall_cycles"}, stall_cycles, (m_sc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_sc));
        check({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(m_to));
    endtask

    // Advance one clock and move the model along with the inputs that were applied
    task automatic tick();
        model_outputs();
        @(posedge clk);
        if (rst) begin
            m_active = 0; m_sc = 0; m_run = 0; m_to = 0;
        end else begin
            if (e_stall[0]) m_sc++;
            m_run = stallreq_mem ? ((m_run < MEM_TIMEOUT) ? m_run + 1 : m_run) : 0;
            if (m_run >= MEM_TIMEOUT) m_to = 1;
            if (e_start) begin
                m_active = 1; m_start = cyc;
            end else if (e_ready && !e_stall[3]) begin
                m_active = 0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic id, input logic dq, input logic mm);
        rst = r; stallreq_id = id; div_req = dq; stallreq_mem = mm;
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0);
        tick();
        tick();
        drive(0, 0, 0, 0);
    endtask

    function automatic vec_t mk(input logic id, input logic dq, input logic mm,
                                input logic [5:0] s, input logic st, input logic b, input logic rd);
        vec_t v;
        v.r = 0; v.id = id; v.dq = dq; v.mm = mm;
        v.stall = s; v.start = st; v.busy = b; v.ready = rd;
        return v;
    endfunction

    initial begin
        cyc = 0; m_active = 0; m_start = 0; m_sc = 0; m_run = 0; m_to = 0;
        rst = 1; stallreq_id = 0; div_req = 0; stallreq_mem = 0;
        @(negedge clk);

        // Load-use, then divide with DIV_LAT=4
        vecs.push_back(mk(1,0,0, 6'b000111, 0,0,0));
        vecs.push_back(mk(0,0,0, 6'b000000, 0,0,0));
        vecs.push_back(mk(0,1,0, 6'b001111, 1,0,0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1,0, 6'b001111, 0,1,0));
        vecs.push_back(mk(0,1,0, 6'b000000, 0,0,1));
        vecs.push_back(mk(0,0,0, 6'b000000, 0,0,0));
        // Divide with MEM stall while in DONE
        vecs.push_back(mk(0,1,0, 6'b001111, 1,0,0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1,0, 6'b001111, 0,1,0));
        vecs.push_back(mk(0,1,1, 6'b011111, 0,0,1));
        vecs.push_back(mk(0,1,1, 6'b011111, 0,0,1));
        vecs.push_back(mk(0,1,0, 6'b000000, 0,0,1));
        vecs.push_back(mk(0,0,0, 6'b000000, 0,0,0));
        // Simultaneous requests
        vecs.push_back(mk(1,1,1, 6'b011111, 0,0,0));
        vecs.push_back(mk(1,1,0, 6'b001111, 1,0,0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1,1,0, 6'b001111, 0,1,0));
        vecs.push_back(mk(1,1,0, 6'b000111, 0,0,1));
        vecs.push_back(mk(0,0,0, 6'b000000, 0,0,0));

        do_reset();
        check_model("reset");
        check("reset.stall_cycles_zero", stall_cycles, 32'd0);
        check("reset.mem_timeout_zero", 32'(mem_timeout), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].id, vecs[i].dq, vecs[i].mm);
            check($sformatf("vec%0d.stall", i), 32'(stall), 32'(vecs[i].stall));
            check($sformatf("vec%0d.div_start", i), 32'(div_start), 32'(vecs[i].start));
            check($sformatf("vec%0d.div_busy", i), 32'(div_busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d.div_ready", i), 32'(div_ready), 32'(vecs[i].ready));
            check_model($sformatf("vec%0d", i));
            if (i == 1) check("loaduse.stall_cycles", stall_cycles, 32'd1);
            tick();
        end

        // Timeout: 7 stalled, 1 free, 8 stalled
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 1);
            check("to.early", 32'(mem_timeout), 32'd0);
            tick();
        end
        drive(0, 0, 0, 0);
        check("to.gap", 32'(mem_timeout), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 1);
            check("to.run", 32'(mem_timeout), 32'd0);
            tick();
        end
        drive(0, 0, 0, 0);
        check("to.rise", 32'(mem_timeout), 32'd1);
        check("to.stall_cycles", stall_cycles, 32'd15);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to.sticky", 32'(mem_timeout), 32'd1);
        end
        drive(1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        check("to.rst_clears", 32'(mem_timeout), 32'd0);
        check_model("to.after_rst");

        // Reset in the middle of a divide
        drive(0, 0, 1, 0); tick();
        drive(0, 0, 1, 0); tick();
        drive(1, 0, 1, 0);
        check("rstbusy.busy_before", 32'(div_busy), 32'd1);
        tick();
        drive(0, 0, 0, 0);
        check("rstbusy.busy", 32'(div_busy), 32'd0);
        check("rstbusy.ready", 32'(div_ready), 32'd0);
        check("rstbusy.stall", 32'(stall), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rstbusy.no_ready", 32'(div_ready), 32'd0);
        end

        // Randomized traffic against the model; div_req stays high while busy
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic r, id, dq, mm;
            r  = ($urandom_range(0, 99) == 0);
            id = ($urandom_range(0, 99) < 30);
            mm = ($urandom_range(0, 99) < 25);
            if (m_active && ((cyc - m_start) <= DIV_LAT)) dq = 1'b1;
            else dq = ($urandom_range(0, 99) < 40);
            drive(r, id, dq, mm);
            check_model($sformatf("rand%0d", i));
            tick();
        end
        // A long MEM stall so the timeout path is exercised under random state
        for (int i = 0; i < MEM_TIMEOUT + 2; i++) begin
            drive(0, 0, div_req & m_active & ((cyc - m_start) <= DIV_LAT), 1);
            check_model("longmem");
            tick();
        end
        drive(0, 0, 0, 0);
        check_model("longmem.end");
        check("longmem.timeout", 32'(mem_timeout), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
